// File: rtl/ctr_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Instantiators use clog2 to size WIDTH from MOD.
package ctr_pkg;

  localparam logic CTR_MODE_WRAP    = 1'b0;
  localparam logic CTR_MODE_ONESHOT = 1'b1;
  localparam logic CTR_DOWN         = 1'b0;
  localparam logic CTR_UP           = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ctr_mod_n.sv
// Modulo-N up/down counter with clear, clamped load,
// wrap or one-shot mode, terminal-count and wrap flags.
module ctr_mod_n
  import ctr_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MOD   = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Dir,
  input  logic             Mode,
  output logic [WIDTH-1:0] Out,
  output logic             Tc,
  output logic             Wrap,
  output logic             Done
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("ctr_mod_n: MOD out of range for WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] ld_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           at_up;
  logic           at_dn;
  logic           at_term;

  // Widened arithmetic so MOD == 2**WIDTH compares cleanly
  assign cnt_ext = {1'b0, cnt_q};
  assign ld_ext  = {1'b0, LoadVal};
  assign inc_ext = cnt_ext + 1'b1;
  assign dec_ext = cnt_ext - 1'b1;
  assign at_up   = (inc_ext == MOD_W);
  assign at_dn   = dec_ext[WIDTH];
  assign at_term = (Dir == CTR_UP) ? at_up : at_dn;

  // Next state: clear > load > enable > hold
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    wrap_d = 1'b0;
    if (Clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (Load) begin
      cnt_d  = (ld_ext < MOD_W) ? LoadVal : LAST;
      done_d = 1'b0;
    end else if (En && !done_q) begin
      if (at_term) begin
        if (Mode == CTR_MODE_ONESHOT) begin
          done_d = 1'b1;
        end else begin
          cnt_d  = (Dir == CTR_UP) ? '0 : LAST;
          wrap_d = 1'b1;
        end
      end else if (Dir == CTR_UP) begin
        cnt_d = inc_ext[WIDTH-1:0];
      end else begin
        cnt_d = dec_ext[WIDTH-1:0];
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign Out  = cnt_q;
  assign Wrap = wrap_q;
  assign Done = done_q;
  assign Tc   = En & at_term & ~done_q;

endmodule

// File: tb/tb_ctr_mod_n.sv
// Self-checking bench: three counter configurations share stimulus,
// expected values come from a behavioural model through a queue.
module tb_ctr_mod_n;

  logic       Clk;
  logic       Reset;
  logic       Clr;
  logic       En;
  logic       Load;
  logic [3:0] lv;
  logic       Dir;
  logic       Mode;

  logic [1:0] a_out;
  logic [3:0] b_out;
  logic [2:0] c_out;
  logic       a_tc, b_tc, c_tc;
  logic       a_wr, b_wr, c_wr;
  logic       a_dn, b_dn, c_dn;

  logic [3:0] o_out  [3];
  logic       o_tc   [3];
  logic       o_wrap [3];
  logic       o_done [3];

  int errors = 0;
  int checks = 0;

  int mods   [3] = '{3, 10, 8};
  int widths [3] = '{2, 4, 3};
  int mcnt   [3];
  bit mdone  [3];
  bit mwrap  [3];

  typedef struct {
    int         inst;
    logic [3:0] out;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t sbq[$];

  ctr_mod_n u_a (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .En(En), .Load(Load),
    .LoadVal(lv[1:0]), .Dir(Dir), .Mode(Mode),
    .Out(a_out), .Tc(a_tc), .Wrap(a_wr), .Done(a_dn)
  );

  ctr_mod_n #(.WIDTH(4), .MOD(10)) u_b (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .En(En), .Load(Load),
    .LoadVal(lv), .Dir(Dir), .Mode(Mode),
    .Out(b_out), .Tc(b_tc), .Wrap(b_wr), .Done(b_dn)
  );

  ctr_mod_n #(.WIDTH(3), .MOD(8)) u_c (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .En(En), .Load(Load),
    .LoadVal(lv[2:0]), .Dir(Dir), .Mode(Mode),
    .Out(c_out), .Tc(c_tc), .Wrap(c_wr), .Done(c_dn)
  );

  assign o_out[0]  = {2'b00, a_out};
  assign o_out[1]  = b_out;
  assign o_out[2]  = {1'b0, c_out};
  assign o_tc[0]   = a_tc;
  assign o_tc[1]   = b_tc;
  assign o_tc[2]   = c_tc;
  assign o_wrap[0] = a_wr;
  assign o_wrap[1] = b_wr;
  assign o_wrap[2] = c_wr;
  assign o_done[0] = a_dn;
  assign o_done[1] = b_dn;
  assign o_done[2] = c_dn;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int i,
                     input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  function automatic logic exp_tc(input int i);
    int term;
    term = Dir ? mods[i] - 1 : 0;
    return En && !mdone[i] && (mcnt[i] == term);
  endfunction

  task automatic model(input int i);
    int m;
    int term;
    int l;
    m = mods[i];
    term = Dir ? m - 1 : 0;
    l = int'(lv) & ((1 << widths[i]) - 1);
    mwrap[i] = 1'b0;
    if (Clr) begin
      mcnt[i]  = 0;
      mdone[i] = 1'b0;
    end else if (Load) begin
      mcnt[i]  = (l < m) ? l : m - 1;
      mdone[i] = 1'b0;
    end else if (En && !mdone[i]) begin
      if (mcnt[i] == term) begin
        if (Mode) begin
          mdone[i] = 1'b1;
        end else begin
          mcnt[i]  = Dir ? 0 : m - 1;
          mwrap[i] = 1'b1;
        end
      end else begin
        mcnt[i] = Dir ? mcnt[i] + 1 : mcnt[i] - 1;
      end
    end
  endtask

  task automatic check_now(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".out"},  i, o_out[i], 4'(mcnt[i]));
      chk({tag, ".wrap"}, i, {3'b0, o_wrap[i]}, {3'b0, mwrap[i]});
      chk({tag, ".done"}, i, {3'b0, o_done[i]}, {3'b0, mdone[i]});
      chk({tag, ".tc"},   i, {3'b0, o_tc[i]}, {3'b0, exp_tc(i)});
    end
  endtask

  task automatic step(input string tag, input logic clr, input logic load,
                      input logic [3:0] v, input logic en,
                      input logic dir, input logic mode);
    exp_t e;
    Clr = clr; Load = load; lv = v; En = en; Dir = dir; Mode = mode;
    for (int i = 0; i < 3; i++) begin
      model(i);
      e.inst = i;
      e.out  = 4'(mcnt[i]);
      e.wrap = mwrap[i];
      e.done = mdone[i];
      sbq.push_back(e);
    end
    @(posedge Clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".out"},  e.inst, o_out[e.inst], e.out);
      chk({tag, ".wrap"}, e.inst, {3'b0, o_wrap[e.inst]}, {3'b0, e.wrap});
      chk({tag, ".done"}, e.inst, {3'b0, o_done[e.inst]}, {3'b0, e.done});
      chk({tag, ".tc"},   e.inst, {3'b0, o_tc[e.inst]}, {3'b0, exp_tc(e.inst)});
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mdone[i] = 1'b0; mwrap[i] = 1'b0;
    end
    #1;
    check_now(tag);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Clr = 0; Load = 0; lv = 0; En = 0; Dir = 1; Mode = 0;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mdone[i] = 1'b0; mwrap[i] = 1'b0;
    end
    #2;
    check_now("reset");
    #5;
    Reset = 1'b0;

    for (int k = 0; k < 7; k++) step("up", 0, 0, 0, 1, 1, 0);

    step("clr", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 11; k++) step("down", 0, 0, 0, 1, 0, 0);

    step("os_ld", 0, 1, 4'd7, 0, 1, 1);
    for (int k = 0; k < 4; k++) step("os_en", 0, 0, 0, 1, 1, 1);
    step("os_ld0", 0, 1, 4'd0, 1, 1, 1);

    step("pr_ld3", 0, 1, 4'd3, 0, 1, 0);
    step("pr_all", 1, 1, 4'd5, 1, 1, 0);
    step("pr_lden", 0, 1, 4'd5, 1, 1, 0);
    step("hold", 0, 0, 0, 0, 1, 0);
    step("clamp", 0, 1, 4'd12, 0, 1, 0);

    step("ar_ld6", 0, 1, 4'd6, 0, 1, 0);
    async_reset("ar6");
    step("ar_resume", 0, 0, 0, 1, 1, 0);

    step("ar_ld9", 0, 1, 4'd9, 0, 1, 1);
    step("ar_done", 0, 0, 0, 1, 1, 1);
    async_reset("ar_dn");
    step("ar_resume2", 0, 0, 0, 1, 1, 0);

    step("fr_ld7", 0, 1, 4'd7, 0, 1, 0);
    step("fr_wrap", 0, 0, 0, 1, 1, 0);
    step("fr_next", 0, 0, 0, 1, 1, 0);
    step("dir_flip", 0, 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
